wb_led_sequencer: RTL
=====================

Name: wb_led_sequencer

Overview:
Wishbone-controlled LED pattern scheduler; it owns the bus path into the LED register peripheral. CPU configures a 4-step pattern table, step period and loop mode through a pipelined Wishbone slave port. A pipelined Wishbone master port issues single-beat writes of each step into the LED peripheral at the configured rate. The block sits between the CPU interconnect and the LED peripheral.

Parameters:
LED_ADDR, 32'h0000_0000, address driven on o_m_addr for every pattern write
PERIOD_W, 24, width of PERIOD register and step counter
ACK_TIMEOUT, 15, master cycles waited for ack/err after stb accepted before abort

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous reset, active-high
i_wb_addr  in  32  slave address; word select = i_wb_addr[3:2]
i_wb_data  in  32  slave write data
i_wb_sel  in  4  byte enables (ignored; full-word writes)
i_wb_we  in  1  slave write enable
i_wb_cyc  in  1  slave cycle
i_wb_stb  in  1  slave strobe
o_wb_ack  out  1  slave ack
o_wb_data  out  32  slave read data
o_wb_stall  out  1  slave stall, tied 0
o_wb_err  out  1  slave error, tied 0
o_m_cyc  out  1  master cycle
o_m_stb  out  1  master strobe
o_m_we  out  1  master write enable, always 1 while o_m_cyc
o_m_addr  out  32  = LED_ADDR
o_m_data  out  32  {26'b0, step pattern}
o_m_sel  out  4  4'hF
i_m_ack  in  1  master ack
i_m_stall  in  1  master stall
i_m_err  in  1  master error

Behaviour:
- Reset (async, i_reset=1): all registers 0; FSM IDLE; o_wb_ack=0, o_wb_data=0, o_m_cyc=0, o_m_stb=0, o_m_data=0.
- Slave: accept when cyc&stb. o_wb_ack registered, exactly 1 cycle after accept; read data registered alongside. Back-to-back strobes each acked.
- Register map (word index):
  0 CTRL rw: [0] RUN, [1] LOOP, [3:2] LAST (last step index 0..3); ro: [8] BUSY (FSM != IDLE), [10:9] current index, [12] ERR sticky; write with bit12=1 clears ERR.
  1 PERIOD rw: [PERIOD_W-1:0] cycles between steps; 0 treated as 1.
  2 PATTERN rw: step0=[5:0], step1=[13:8], step2=[21:16], step3=[29:24].
  3 reserved: reads 0, writes ignored.
- FSM states IDLE, REQ, ACKW, WAIT.
  IDLE: on CTRL write taking RUN 0->1: idx=0, ERR untouched, -> REQ next cycle.
  REQ: o_m_cyc=o_m_stb=1, o_m_data latched from PATTERN[idx] on REQ entry. When !i_m_stall: stb drops next cycle, -> ACKW (ack in same cycle as acceptance treated as completion).
  ACKW: o_m_cyc=1, o_m_stb=0; timeout counter runs.
    i_m_ack: if idx==LAST: LOOP&RUN -> idx=0, WAIT; else RUN cleared, IDLE. Else idx+1, RUN ? WAIT : IDLE.
    i_m_err or ACK_TIMEOUT expiry: cyc drops, ERR=1, RUN=0, -> IDLE.
  WAIT: counter loaded with max(PERIOD,1)-1 on entry, decrements; at 0 -> REQ. RUN cleared -> IDLE next cycle.
- Step-to-step spacing with zero-latency slave: PERIOD + 2 cycles from stb to next stb.
- Clearing RUN during REQ/ACKW: transaction completes (cyc never dropped mid-transfer), then IDLE.
- CPU writes to PERIOD/PATTERN take effect at next WAIT entry / REQ entry; in-flight o_m_data never changes.
- CTRL write with RUN=1 while BUSY: LOOP/LAST updated, no restart. LAST lowered below current idx: sequence ends at idx 3 wrap (idx compared only with ==; idx wraps 3->0).

Decomposition:
- Shared package: register word indices, CTRL bit positions, FSM state encoding, default LED_ADDR.
- One natural sub-module: wb_led_seq_regs (slave decode, CTRL/PERIOD/PATTERN storage, read mux, registered ack); FSM and master port in top.

Test Plan:
- Write PATTERN=32'h2A15_3F01, PERIOD=4, CTRL=0x0D (RUN, LAST=3) -> master writes 0x01,0x3F,0x15,0x2A, stb-to-stb 6 cycles, then BUSY=0, RUN=0.
- CTRL=0x07 (RUN, LOOP, LAST=1), PATTERN step0=0x05 step1=0x0A -> alternating 0x05/0x0A indefinitely; write CTRL=0 during WAIT -> IDLE next cycle, no further stb.
- i_m_stall held 3 cycles during REQ -> stb/cyc/data stable 4 cycles, single transfer on release.
- Never assert i_m_ack -> cyc drops after ACK_TIMEOUT=15 cycles, CTRL read bit12=1, RUN=0; write bit12 -> ERR=0.
- i_m_err on first transfer -> IDLE, ERR=1; PERIOD=0 run -> steps spaced 3 cycles.
- Assert i_reset mid-ACKW -> o_m_cyc=0 immediately (async), all registers read 0.

Source files
------------

// File: rtl/wb_led_seq_pkg.sv
// wb_led_seq_pkg: register map, CTRL bit positions, FSM encoding and step helpers for the LED sequencer.
package wb_led_seq_pkg;
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_PATTERN = 2'd2;
  localparam int CTRL_RUN  = 0;
  localparam int CTRL_LOOP = 1;
  localparam int CTRL_LAST = 2;
  localparam int CTRL_ERR  = 12;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACKW = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;
  localparam logic [31:0] LED_ADDR_DEF = 32'h0000_0000;
  localparam logic [31:0] PATTERN_MASK = 32'h3F3F_3F3F;
  function automatic logic [5:0] step_of(input logic [31:0] p, input logic [1:0] i);
    return p[{i, 3'b000} +: 6];
  endfunction
endpackage

// File: rtl/wb_led_seq_regs.sv
// wb_led_seq_regs: Wishbone slave decode, CTRL/PERIOD/PATTERN storage, read mux and registered ack.
module wb_led_seq_regs
  import wb_led_seq_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          word,
  input  logic [31:0]         data,
  input  logic                we,
  input  logic                cyc,
  input  logic                stb,
  output logic                ack,
  output logic [31:0]         rdata,
  input  logic                busy,
  input  logic [1:0]          idx,
  input  logic                clr_run,
  input  logic                set_err,
  output logic                run,
  output logic                loop,
  output logic [1:0]          last,
  output logic [PERIOD_W-1:0] period,
  output logic [31:0]         pattern,
  output logic                start
);
  logic acc, wr, err;
  logic [31:0] rd;
  assign acc = cyc & stb;
  assign wr = acc & we;
  assign start = wr && word == REG_CTRL && data[CTRL_RUN] && !run;
  always_comb
    rd = word == REG_CTRL    ? {19'd0, err, 1'b0, idx, busy, 4'd0, last, loop, run} :
         word == REG_PERIOD  ? 32'(period) :
         word == REG_PATTERN ? pattern : '0;
  // FSM events are applied after the CPU write so completion/abort wins a same-cycle race
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ack <= 1'b0;
      rdata <= '0;
      run <= 1'b0;
      loop <= 1'b0;
      last <= '0;
      period <= '0;
      pattern <= '0;
      err <= 1'b0;
    end else begin
      ack <= acc;
      rdata <= acc ? rd : '0;
      if (wr && word == REG_CTRL) begin
        run <= data[CTRL_RUN];
        loop <= data[CTRL_LOOP];
        last <= data[CTRL_LAST +: 2];
        if (data[CTRL_ERR]) err <= 1'b0;
      end
      if (wr && word == REG_PERIOD) period <= data[PERIOD_W-1:0];
      if (wr && word == REG_PATTERN) pattern <= data & PATTERN_MASK;
      if (clr_run) run <= 1'b0;
      if (set_err) err <= 1'b1;
    end
endmodule

// File: rtl/wb_led_sequencer.sv
// wb_led_sequencer: Wishbone-configured 4-step LED pattern scheduler driving single-beat master writes.
module wb_led_sequencer
  import wb_led_seq_pkg::*;
#(
  parameter logic [31:0] LED_ADDR    = LED_ADDR_DEF,
  parameter int          PERIOD_W    = 24,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_wb_stall,
  output logic        o_wb_err,
  output logic        o_m_cyc,
  output logic        o_m_stb,
  output logic        o_m_we,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_data,
  output logic [3:0]  o_m_sel,
  input  logic        i_m_ack,
  input  logic        i_m_stall,
  input  logic        i_m_err
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [1:0] state, idx, last;
  logic [PERIOD_W-1:0] cnt, period;
  logic [TW-1:0] tmo;
  logic [5:0] m_data;
  logic [31:0] pattern;
  logic run, loop, start, xfer, m_ok, m_err, at_last, go_wait, clr_run, unused_ok;
  assign unused_ok = ^{i_wb_sel, i_wb_addr[31:4], i_wb_addr[1:0]};
  wb_led_seq_regs #(.PERIOD_W(PERIOD_W)) u_regs (
    .clk(i_clk), .rst(i_reset), .word(i_wb_addr[3:2]), .data(i_wb_data), .we(i_wb_we),
    .cyc(i_wb_cyc), .stb(i_wb_stb), .ack(o_wb_ack), .rdata(o_wb_data),
    .busy(state != ST_IDLE), .idx(idx), .clr_run(clr_run), .set_err(m_err),
    .run(run), .loop(loop), .last(last), .period(period), .pattern(pattern), .start(start)
  );
  // An ack arriving with the accepting strobe completes the transfer directly from REQ
  always_comb begin
    xfer = (state == ST_REQ && !i_m_stall) || state == ST_ACKW;
    m_err = xfer && (i_m_err || (state == ST_ACKW && !i_m_ack && tmo == TW'(ACK_TIMEOUT - 1)));
    m_ok = xfer && i_m_ack && !i_m_err;
    at_last = idx == last;
    go_wait = m_ok && run && (!at_last || loop);
    clr_run = m_err || (m_ok && !go_wait) || (state == ST_WAIT && !run);
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= ST_IDLE;
      idx <= '0;
      cnt <= '0;
      tmo <= '0;
      m_data <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        state <= ST_REQ;
        idx <= '0;
        m_data <= step_of(pattern, 2'd0);
      end
    end else if (m_err || (m_ok && !go_wait)) begin
      state <= ST_IDLE;
      if (m_ok && !at_last) idx <= idx + 2'd1;
    end else if (m_ok) begin
      state <= ST_WAIT;
      idx <= at_last ? 2'd0 : idx + 2'd1;
      cnt <= period == '0 ? '0 : period - 1'b1;
    end else if (state == ST_REQ) begin
      if (!i_m_stall) begin
        state <= ST_ACKW;
        tmo <= '0;
      end
    end else if (state == ST_ACKW) tmo <= tmo + 1'b1;
    else if (!run) state <= ST_IDLE;
    else if (cnt == '0) begin
      state <= ST_REQ;
      m_data <= step_of(pattern, idx);
    end else cnt <= cnt - 1'b1;
  assign o_m_cyc = state == ST_REQ || state == ST_ACKW;
  assign o_m_stb = state == ST_REQ;
  assign o_m_we = o_m_cyc;
  assign o_m_addr = LED_ADDR;
  assign o_m_data = {26'd0, m_data};
  assign o_m_sel = 4'hF;
  assign o_wb_stall = 1'b0;
  assign o_wb_err = 1'b0;
endmodule
